// File: rtl/usb_pulpino_word_buffer_if.sv
// usb_pulpino_word_buffer_if
//   Bundles the host-side FIFO access signals and the gpio_pulpino_comm link
//   signals of usb_pulpino_word_buffer.
//   slave  : the buffer itself (drives usb_rd_data, counts, status, read_data, do_read)
//   master : the environment (drives usb_* requests, err_clr and link completions)
interface usb_pulpino_word_buffer_if #(
    parameter int DEPTH_LOG2 = 3
);
    // host side
    logic                  usb_wr_en;
    logic [31:0]           usb_wr_data;
    logic                  usb_rd_en;
    logic [31:0]           usb_rd_data;
    logic [DEPTH_LOG2:0]   tx_count;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  tx_full;
    logic                  rx_empty;
    logic                  busy;
    logic [3:0]            err_flags;
    logic                  err_clr;
    // link side
    logic [31:0]           read_data;
    logic                  do_read;
    logic                  data_in_done;
    logic [31:0]           write_data;
    logic                  data_out_done;

    modport slave (
        input  usb_wr_en, usb_wr_data, usb_rd_en, err_clr,
               data_in_done, write_data, data_out_done,
        output usb_rd_data, tx_count, rx_count, tx_full, rx_empty, busy,
               err_flags, read_data, do_read
    );

    modport master (
        output usb_wr_en, usb_wr_data, usb_rd_en, err_clr,
               data_in_done, write_data, data_out_done,
        input  usb_rd_data, tx_count, rx_count, tx_full, rx_empty, busy,
               err_flags, read_data, do_read
    );
endinterface

// File: rtl/usb_pulpino_word_buffer.sv
// usb_pulpino_word_buffer
//   Host words queue in a TX FIFO and are handed to the GPIO link one at a
//   time (read_data + one-cycle do_read), each transfer waited on until
//   data_in_done rises or the optional timeout expires. Words reassembled by
//   the link (write_data on a data_out_done rising edge) land in an RX FIFO
//   that the host drains first-word-fall-through.
//   Ports: clk, reset_i (async, active high), bus (usb_pulpino_word_buffer_if.slave).
//   err_flags (sticky): [0] tx_overflow [1] rx_overflow [2] rx_underflow [3] timeout.

// Circular 32-bit FIFO with gated push/pop and per-cycle error pulses.
module usb_pulpino_word_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                push_req,
    input  logic                pop_req,
    input  logic [31:0]         wdata,
    output logic [31:0]         head,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty,
    output logic                overflow,
    output logic                underflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty     = (count == '0);
    assign full      = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign pop_ok    = pop_req & ~empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok   = push_req & (~full | pop_ok);
    assign overflow  = push_req & ~push_ok;
    assign underflow = pop_req & empty;
    assign head      = empty ? 32'h0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module usb_pulpino_word_buffer #(
    parameter int DEPTH_LOG2     = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_i,
    usb_pulpino_word_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1) + 1;
    // Counter starts at 0 in the first WAIT_DONE cycle, so the last allowed
    // cycle is TIMEOUT_CYCLES-1.
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic          tx_pop;
    logic          timeout_evt;
    logic          timeout_hit;
    logic [TW-1:0] tcnt;
    logic [31:0]   read_data_q;
    logic          do_read_q;
    logic [3:0]    err_q;
    logic          in_prev, out_prev;
    logic          in_rise, out_rise;

    logic [31:0]   tx_head;
    logic          tx_empty;
    logic          tx_overflow;
    logic          unused_tx_underflow;
    logic          rx_empty_w;
    logic          rx_overflow;
    logic          rx_underflow;

    assign in_rise     = bus.data_in_done & ~in_prev;
    assign out_rise    = bus.data_out_done & ~out_prev;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == T_LAST);

    usb_pulpino_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push_req  (bus.usb_wr_en),
        .pop_req   (tx_pop),
        .wdata     (bus.usb_wr_data),
        .head      (tx_head),
        .count     (bus.tx_count),
        .full      (bus.tx_full),
        .empty     (tx_empty),
        .overflow  (tx_overflow),
        .underflow (unused_tx_underflow)
    );

    usb_pulpino_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .reset_i   (reset_i),
        .push_req  (out_rise),
        .pop_req   (bus.usb_rd_en),
        .wdata     (bus.write_data),
        .head      (bus.usb_rd_data),
        .count     (bus.rx_count),
        .full      (),
        .empty     (rx_empty_w),
        .overflow  (rx_overflow),
        .underflow (rx_underflow)
    );

    always_comb begin
        state_nxt   = state;
        tx_pop      = 1'b0;
        timeout_evt = 1'b0;
        unique case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                // Completion edge beats a coincident timeout.
                if (in_rise) begin
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    state_nxt   = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            read_data_q <= '0;
            do_read_q   <= 1'b0;
            tcnt        <= '0;
            err_q       <= '0;
            in_prev     <= 1'b0;
            out_prev    <= 1'b0;
        end else begin
            state     <= state_nxt;
            do_read_q <= tx_pop;
            if (tx_pop) read_data_q <= tx_head;
            if (state == ISSUE)          tcnt <= '0;
            else if (state == WAIT_DONE) tcnt <= tcnt + 1'b1;
            if (bus.err_clr) err_q <= '0;
            else             err_q <= err_q | {timeout_evt, rx_underflow, rx_overflow, tx_overflow};
            in_prev  <= bus.data_in_done;
            out_prev <= bus.data_out_done;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.do_read   = do_read_q;
    assign bus.busy      = (state != IDLE);
    assign bus.err_flags = err_q;
    assign bus.rx_empty  = rx_empty_w;
endmodule

// File: tb/tb_usb_pulpino_word_buffer.sv
module tb_usb_pulpino_word_buffer;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_i;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    usb_pulpino_word_buffer_if #(.DEPTH_LOG2(3)) bus_a ();
    usb_pulpino_word_buffer_if #(.DEPTH_LOG2(3)) bus_b ();

    // bus_b mirrors bus_a stimulus into a DUT with the timeout disabled
    assign bus_b.usb_wr_en     = bus_a.usb_wr_en;
    assign bus_b.usb_wr_data   = bus_a.usb_wr_data;
    assign bus_b.usb_rd_en     = bus_a.usb_rd_en;
    assign bus_b.err_clr       = bus_a.err_clr;
    assign bus_b.data_in_done  = bus_a.data_in_done;
    assign bus_b.write_data    = bus_a.write_data;
    assign bus_b.data_out_done = bus_a.data_out_done;

    usb_pulpino_word_buffer #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .reset_i(reset_i), .bus(bus_a));
    usb_pulpino_word_buffer #(.DEPTH_LOG2(3), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset_i(reset_i), .bus(bus_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];
    int          m_age;      // -1 idle; 0 cycle of do_read; k>=1 k-th cycle awaiting completion
    logic [31:0] m_rd;
    logic [3:0]  m_err, m_ne;
    logic        m_pin, m_pout, m_in_rise, m_out_rise;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            m_tx.delete(); m_rx.delete();
            m_age = -1; m_rd = '0; m_err = '0; m_pin = 0; m_pout = 0;
        end else begin
            m_ne       = '0;
            m_in_rise  = bus_a.data_in_done & ~m_pin;
            m_out_rise = bus_a.data_out_done & ~m_pout;
            if (m_age < 0) begin
                if (m_tx.size() > 0) begin m_rd = m_tx.pop_front(); m_age = 0; end
            end else if (m_age == 0) m_age = 1;
            else if (m_in_rise) m_age = -1;
            else if (m_age == TMO) begin m_age = -1; m_ne[3] = 1; end
            else m_age++;
            if (bus_a.usb_wr_en) begin
                if (m_tx.size() < 8) m_tx.push_back(bus_a.usb_wr_data); else m_ne[0] = 1;
            end
            if (bus_a.usb_rd_en) begin
                if (m_rx.size() == 0) m_ne[2] = 1; else void'(m_rx.pop_front());
            end
            if (m_out_rise) begin
                if (m_rx.size() < 8) m_rx.push_back(bus_a.write_data); else m_ne[1] = 1;
            end
            m_err  = bus_a.err_clr ? 4'h0 : (m_err | m_ne);
            m_pin  = bus_a.data_in_done;
            m_pout = bus_a.data_out_done;
        end
    end

    always @(negedge clk) begin
        if (!reset_i) begin
            check("m_do_read",   bus_a.do_read,   (m_age == 0));
            check("m_busy",      bus_a.busy,      (m_age >= 0));
            check("m_read_data", bus_a.read_data, m_rd);
            check("m_tx_count",  bus_a.tx_count,  m_tx.size());
            check("m_tx_full",   bus_a.tx_full,   (m_tx.size() == 8));
            check("m_rx_count",  bus_a.rx_count,  m_rx.size());
            check("m_rx_empty",  bus_a.rx_empty,  (m_rx.size() == 0));
            check("m_rd_data",   bus_a.usb_rd_data, (m_rx.size() > 0) ? m_rx[0] : 32'h0);
            check("m_err",       bus_a.err_flags, m_err);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rxv [3] = '{32'hCD, 32'hAB34, 32'h12};
    int n;

    initial begin
        reset_i = 1;
        bus_a.usb_wr_en = 0; bus_a.usb_wr_data = 0; bus_a.usb_rd_en = 0; bus_a.err_clr = 0;
        bus_a.data_in_done = 0; bus_a.write_data = 0; bus_a.data_out_done = 0;
        step(2);
        reset_i = 0;
        check("rst_do_read", bus_a.do_read, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_err", bus_a.err_flags, 0);
        check("rst_rd_data", bus_a.usb_rd_data, 0);
        check("rst_rx_empty", bus_a.rx_empty, 1);

        // single word round trip
        bus_a.usb_wr_en = 1; bus_a.usb_wr_data = 32'h1234ABCD; step;
        bus_a.usb_wr_en = 0;
        check("t1_tx_count", bus_a.tx_count, 1);
        step;
        check("t1_do_read", bus_a.do_read, 1);
        check("t1_read_data", bus_a.read_data, 32'h1234ABCD);
        check("t1_busy", bus_a.busy, 1);
        check("t1_tx_empty", bus_a.tx_count, 0);
        step;
        check("t1_do_read_low", bus_a.do_read, 0);
        check("t1_busy_wait", bus_a.busy, 1);
        bus_a.data_in_done = 1; step;
        check("t1_idle", bus_a.busy, 0);
        check("t1_read_hold", bus_a.read_data, 32'h1234ABCD);
        bus_a.data_in_done = 0;

        // fill TX past depth; dut_b never times out
        for (int i = 0; i < 10; i++) begin
            bus_a.usb_wr_en = 1; bus_a.usb_wr_data = i; step;
            if (i == 8) begin
                check("t2_b_count8", bus_b.tx_count, 8);
                check("t2_b_no_ovf", bus_b.err_flags, 0);
            end
            if (i == 9) begin
                check("t2_b_count_hold", bus_b.tx_count, 8);
                check("t2_b_ovf", bus_b.err_flags, 4'b0001);
            end
        end
        bus_a.usb_wr_en = 0;
        step(40);
        check("t2_b_still_busy", bus_b.busy, 1);
        check("t2_b_no_tmo", bus_b.err_flags, 4'b0001);
        check("t2_b_read_data", bus_b.read_data, 0);
        bus_a.err_clr = 1; step; bus_a.err_clr = 0;
        check("t2_b_clr", bus_b.err_flags, 0);
        reset_i = 1; step; reset_i = 0; step;

        // RX capture and drain
        for (int k = 0; k < 3; k++) begin
            bus_a.write_data = rxv[k]; bus_a.data_out_done = 1; step;
            bus_a.data_out_done = 0; step;
        end
        check("t3_rx_count", bus_a.rx_count, 3);
        check("t3_head0", bus_a.usb_rd_data, 32'hCD);
        bus_a.usb_rd_en = 1; step;
        check("t3_head1", bus_a.usb_rd_data, 32'hAB34);
        step;
        check("t3_head2", bus_a.usb_rd_data, 32'h12);
        step;
        check("t3_empty", bus_a.rx_empty, 1);
        check("t3_empty_data", bus_a.usb_rd_data, 0);
        step; bus_a.usb_rd_en = 0;
        check("t3_underflow", bus_a.err_flags, 4'b0100);
        bus_a.err_clr = 1; bus_a.usb_rd_en = 1; step;
        bus_a.err_clr = 0; bus_a.usb_rd_en = 0;
        check("t3_clr_prio", bus_a.err_flags, 0);

        // level held high -> one push
        bus_a.write_data = 32'h55; bus_a.data_out_done = 1; step(10);
        bus_a.data_out_done = 0; step;
        check("t3_held_once", bus_a.rx_count, 1);
        bus_a.usb_rd_en = 1; step; bus_a.usb_rd_en = 0;

        // RX full: push+pop keeps count, plain push overflows
        for (int k = 0; k < 8; k++) begin
            bus_a.write_data = 32'h100 + k; bus_a.data_out_done = 1; step;
            bus_a.data_out_done = 0; step;
        end
        check("t3_rx_full", bus_a.rx_count, 8);
        bus_a.write_data = 32'h200; bus_a.data_out_done = 1; bus_a.usb_rd_en = 1; step;
        bus_a.data_out_done = 0; bus_a.usb_rd_en = 0;
        check("t3_full_pp_cnt", bus_a.rx_count, 8);
        check("t3_full_pp_err", bus_a.err_flags, 0);
        check("t3_full_pp_head", bus_a.usb_rd_data, 32'h101);
        step;
        bus_a.write_data = 32'h300; bus_a.data_out_done = 1; step;
        bus_a.data_out_done = 0;
        check("t3_rx_ovf", bus_a.err_flags, 4'b0010);
        bus_a.err_clr = 1; bus_a.usb_rd_en = 1; step; bus_a.err_clr = 0;
        step(7); bus_a.usb_rd_en = 0;
        check("t3_drained", bus_a.rx_empty, 1);

        // timeout after 16 waiting cycles
        bus_a.usb_wr_en = 1; bus_a.usb_wr_data = 32'hDEADBEEF; step;
        bus_a.usb_wr_en = 0;
        n = 0;
        for (int c = 0; c < 100; c++) begin
            step;
            if (bus_a.busy) n++;
            else if (n > 0) break;
        end
        check("t4_busy_cycles", n, 17);
        check("t4_tmo_flag", bus_a.err_flags, 4'b1000);
        check("t4_b_busy", bus_b.busy, 1);
        check("t4_b_no_tmo", bus_b.err_flags, 0);
        bus_a.err_clr = 1; step; bus_a.err_clr = 0;
        check("t4_clr", bus_a.err_flags, 0);

        // completion edge in the last waiting cycle beats the timeout
        bus_a.usb_wr_en = 1; bus_a.usb_wr_data = 32'hCAFEF00D; step;
        bus_a.usb_wr_en = 0; step(17);
        bus_a.data_in_done = 1; step;
        check("t4_edge_wins_idle", bus_a.busy, 0);
        check("t4_edge_wins_err", bus_a.err_flags, 0);
        bus_a.data_in_done = 0; step;

        // async reset mid-wait
        for (int i = 0; i < 4; i++) begin
            bus_a.usb_wr_en = 1; bus_a.usb_wr_data = 32'hA0 + i; step;
        end
        bus_a.usb_wr_en = 0;
        check("t5_tx3", bus_a.tx_count, 3);
        check("t5_busy", bus_a.busy, 1);
        #2 reset_i = 1;
        #1;
        check("t5_async_do_read", bus_a.do_read, 0);
        check("t5_async_busy", bus_a.busy, 0);
        check("t5_async_tx", bus_a.tx_count, 0);
        check("t5_async_rd", bus_a.read_data, 0);
        step; reset_i = 0; step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
